dmem_axi_responder: RTL and testbench

- Serves the core's data-memory port, the responder for the core's initiator side. The core drives a one-cycle-strobe SRAM-like request: mem_en, mem_addr, mem_wen, mem_wdata.
- Converts each request into one single-beat AXI4-Lite read or write transaction. Returns mem_rdata and drives d_stall to freeze the core's M stage until the access completes.
- Sits between the core's data port and the SoC crossbar.

---
 rtl/dmem_axi_responder_pkg.sv | 18 +
 rtl/dmem_axi_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_axi_responder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_axi_responder_pkg.sv
// Shared types for the data-memory AXI4-Lite responder.
// FSM state encoding and AXI response codes.
package dmem_axi_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/dmem_axi_responder.sv
// Core data port to single-beat AXI4-Lite bridge.
// Stalls the core M stage until the bus access completes.
module dmem_axi_responder
  import dmem_axi_responder_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [STRB_W-1:0] mem_wen,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              d_stall,
  output logic              bus_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    ~{{(ADDR_W-2){1'b0}}, 2'b11};

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [STRB_W-1:0] r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_bus_err;
  logic              r_aw_done;
  logic              r_w_done;
  logic              w_bus_err_next;
  logic              w_aw_done_next;
  logic              w_w_done_next;
  logic              w_latch;
  logic              w_cap_rd;
  logic              w_aw_all;
  logic              w_w_all;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    w_bus_err_next = 1'b0;
    w_aw_done_next = r_aw_done;
    w_w_done_next  = r_w_done;
    w_latch        = 1'b0;
    w_cap_rd       = 1'b0;
    w_aw_all       = r_aw_done | (awvalid & awready);
    w_w_all        = r_w_done | (wvalid & wready);
    unique case (r_state)
      IDLE: begin
        if (mem_en) begin
          w_latch      = 1'b1;
          w_state_next = (|mem_wen) ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (arready) w_state_next = RD_DATA;
      end
      RD_DATA: begin
        if (rvalid) begin
          w_cap_rd       = 1'b1;
          w_bus_err_next = (rresp != RESP_OKAY);
          w_state_next   = DONE;
        end
      end
      WR_REQ: begin
        // Both handshakes may land in the same cycle.
        if (w_aw_all && w_w_all) begin
          w_aw_done_next = 1'b0;
          w_w_done_next  = 1'b0;
          w_state_next   = WR_RESP;
        end else begin
          w_aw_done_next = w_aw_all;
          w_w_done_next  = w_w_all;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          w_bus_err_next = (bresp != RESP_OKAY);
          w_state_next   = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr    <= '0;
      r_wen     <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_bus_err <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_bus_err <= w_bus_err_next;
      r_aw_done <= w_aw_done_next;
      r_w_done  <= w_w_done_next;
      if (w_latch) begin
        r_addr  <= mem_addr & ALIGN_MASK;
        r_wen   <= mem_wen;
        r_wdata <= mem_wdata;
      end
      if (w_cap_rd) r_rdata <= rdata;
    end
  end

  assign arvalid   = (r_state == RD_ADDR);
  assign rready    = (r_state == RD_DATA);
  assign awvalid   = (r_state == WR_REQ) && !r_aw_done;
  assign wvalid    = (r_state == WR_REQ) && !r_w_done;
  assign bready    = (r_state == WR_RESP);
  assign araddr    = r_addr;
  assign awaddr    = r_addr;
  assign wdata     = r_wdata;
  assign wstrb     = r_wen;
  assign mem_rdata = r_rdata;
  assign bus_err   = r_bus_err;
  assign d_stall   = (r_state == IDLE) ? mem_en
                   : (r_state != DONE);

endmodule

// File: tb/tb_dmem_axi_responder.sv
// Directed bench for dmem_axi_responder.
// Slave inputs are driven by hand, cycle by cycle.
module tb_dmem_axi_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        d_stall;
  logic        bus_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_axi_responder dut (
    .clk(clk), .rst(rst),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .d_stall(d_stall),
    .bus_err(bus_err),
    .araddr(araddr), .arvalid(arvalid),
    .arready(arready),
    .rdata(rdata), .rresp(rresp),
    .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid),
    .awready(awready),
    .wdata(wdata), .wstrb(wstrb),
    .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_bus();
    arready = 0; rvalid = 0; rresp = 0;
    rdata = 0; awready = 0; wready = 0;
    bvalid = 0; bresp = 0;
  endtask

  task automatic req(input logic [31:0] a,
                     input logic [3:0] we,
                     input logic [31:0] d);
    mem_en = 1; mem_addr = a;
    mem_wen = we; mem_wdata = d;
  endtask

  initial begin
    rst = 0; mem_en = 0; mem_addr = 0;
    mem_wen = 0; mem_wdata = 0;
    idle_bus();
    #1;
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_valids",
        {arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_addr", araddr, 0);
    tick();
    rst = 1;
    tick();

    // read, zero-wait slave
    req(32'h8000_0104, 4'b0, 0);
    arready = 1; rvalid = 1;
    rdata = 32'hDEAD_BEEF;
    #1 chk("rd_idle_stall", d_stall, 1);
    tick();
    chk("rd_arvalid", arvalid, 1);
    chk("rd_araddr", araddr, 32'h8000_0104);
    chk("rd_stall1", d_stall, 1);
    tick();
    chk("rd_rready", rready, 1);
    chk("rd_stall2", d_stall, 1);
    tick();
    chk("rd_done_stall", d_stall, 0);
    chk("rd_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("rd_err", bus_err, 0);
    tick();
    mem_en = 0; idle_bus();
    #1 chk("rd_after_stall", d_stall, 0);
    tick();

    // write, wready two cycles after awready
    req(32'h8000_0203, 4'b1000, 32'hAA00_0000);
    awready = 1;
    tick();
    chk("wr_aw_w_valid", {awvalid, wvalid}, 2'b11);
    chk("wr_awaddr", awaddr, 32'h8000_0200);
    chk("wr_wstrb", wstrb, 4'b1000);
    tick();
    chk("wr_aw_first", {awvalid, wvalid}, 2'b01);
    chk("wr_wdata", wdata, 32'hAA00_0000);
    tick();
    chk("wr_w_hold", {awvalid, wvalid}, 2'b01);
    chk("wr_stall", d_stall, 1);
    wready = 1;
    tick();
    chk("wr_bready", bready, 1);
    chk("wr_no_valid", {awvalid, wvalid}, 0);
    chk("wr_resp_stall", d_stall, 1);
    bvalid = 1;
    tick();
    chk("wr_done_stall", d_stall, 0);
    chk("wr_err", bus_err, 0);
    chk("wr_keeps_rdata", mem_rdata, 32'hDEAD_BEEF);
    tick();
    mem_en = 0; idle_bus();
    tick();

    // same-cycle aw/w handshake, SLVERR
    req(32'h0000_0010, 4'b1111, 32'h1111_2222);
    awready = 1; wready = 1;
    bvalid = 1; bresp = 2'b10;
    tick();
    chk("se_both_valid", {awvalid, wvalid}, 2'b11);
    tick();
    chk("se_bready", bready, 1);
    tick();
    chk("se_err_pulse", bus_err, 1);
    chk("se_done_stall", d_stall, 0);
    tick();
    mem_en = 0; idle_bus();
    #1;
    chk("se_err_clear", bus_err, 0);
    chk("se_no_retry", {awvalid, wvalid, d_stall}, 0);
    tick();

    // back-to-back read then write
    req(32'h0000_0020, 4'b0, 0);
    arready = 1; rvalid = 1;
    rdata = 32'h1234_5678;
    awready = 1; wready = 1; bvalid = 1;
    tick(); tick(); tick();
    chk("bb_rd_done", mem_rdata, 32'h1234_5678);
    chk("bb_rd_stall", d_stall, 0);
    tick();
    req(32'h0000_0024, 4'b0011, 32'h0000_BBBB);
    #1 chk("bb_wr_accept", d_stall, 1);
    tick();
    chk("bb_awvalid", awvalid, 1);
    chk("bb_awaddr", awaddr, 32'h0000_0024);
    tick(); tick();
    chk("bb_wr_done", d_stall, 0);
    chk("bb_rdata_kept", mem_rdata, 32'h1234_5678);
    tick();
    mem_en = 0; idle_bus();
    tick();

    // arready held low for 10 cycles
    req(32'h0000_0040, 4'b0, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("ar_wait_valid", arvalid, 1);
      chk("ar_wait_addr", araddr, 32'h0000_0040);
      chk("ar_wait_stall", d_stall, 1);
      tick();
    end
    arready = 1; rvalid = 1;
    rdata = 32'h0BAD_F00D; rresp = 2'b11;
    tick();
    chk("ar_rready", rready, 1);
    tick();
    chk("ar_err_pulse", bus_err, 1);
    chk("ar_err_data", mem_rdata, 32'h0BAD_F00D);
    tick();
    mem_en = 0; idle_bus();
    tick();

    // reset asserted in RD_DATA
    req(32'h0000_0080, 4'b0, 0);
    arready = 1;
    tick(); tick();
    chk("rs_rready", rready, 1);
    #2;
    rst = 0; mem_en = 0; idle_bus();
    #1;
    chk("rs_valids",
        {arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("rs_rdata", mem_rdata, 0);
    chk("rs_err", bus_err, 0);
    chk("rs_stall", d_stall, 0);
    tick();
    rst = 1;
    tick();
    chk("rs_idle",
        {arvalid, rready, d_stall, bus_err}, 0);
    mem_en = 1;
    #1 chk("rs_idle_accept", d_stall, 1);
    tick();
    chk("rs_new_rd", arvalid, 1);
    chk("rs_new_addr", araddr, 32'h0000_0080);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
